// File: rtl/my_clint.sv
// my_clint: single-hart RISC-V CLINT (msip, mtimecmp, mtime) on a native valid/ready bus.
// Define CLINT_RTC_EN to advance mtime once every RTC_DIV clocks instead of every clock.
module my_clint #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RTC_DIV = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                mtip,
  output logic                msip
);

  localparam logic [13:0] A_MSIP    = 14'h0000;
  localparam logic [13:0] A_CMP_LO  = 14'h1000;
  localparam logic [13:0] A_CMP_HI  = 14'h1001;
  localparam logic [13:0] A_TIME_LO = 14'h2FFE;
  localparam logic [13:0] A_TIME_HI = 14'h2FFF;

  logic        tick;
  logic [13:0] word;
  logic        accept;
  logic        wr;
  logic [63:0] mtime;
  logic [63:0] mtime_inc;
  logic [63:0] mtimecmp;
  logic        msip_r;
  logic [31:0] rd_val;
  logic        unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

`ifdef CLINT_RTC_EN
  localparam int PW = (RTC_DIV > 1) ? $clog2(RTC_DIV) : 1;
  logic [PW-1:0] presc;

  assign tick = (presc == PW'(RTC_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  assign unused_bits = ^{address[ADDR_W-1:16], address[1:0]};
`else
  assign tick = 1'b1;
  assign unused_bits = ^{address[ADDR_W-1:16], address[1:0]} ^ (RTC_DIV < 1);
`endif

  assign word   = address[15:2];
  assign accept = valid & ~ready;
  assign wr     = accept & (wstrb != '0);

  assign mtime_inc = mtime + {63'd0, tick};

  // A written mtime half takes the bus value; the other half keeps counting, carry included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
      msip_r   <= 1'b0;
    end else begin
      mtime <= mtime_inc;
      if (wr && word == A_TIME_LO) mtime[31:0]  <= merge(mtime[31:0], wdata, wstrb);
      if (wr && word == A_TIME_HI) mtime[63:32] <= merge(mtime[63:32], wdata, wstrb);
      if (wr && word == A_CMP_LO)  mtimecmp[31:0]  <= merge(mtimecmp[31:0], wdata, wstrb);
      if (wr && word == A_CMP_HI)  mtimecmp[63:32] <= merge(mtimecmp[63:32], wdata, wstrb);
      if (wr && word == A_MSIP && wstrb[0]) msip_r <= wdata[0];
    end
  end

  always_comb begin
    rd_val = '0;
    case (word)
      A_MSIP:    rd_val = {31'd0, msip_r};
      A_CMP_LO:  rd_val = mtimecmp[31:0];
      A_CMP_HI:  rd_val = mtimecmp[63:32];
      A_TIME_LO: rd_val = mtime[31:0];
      A_TIME_HI: rd_val = mtime[63:32];
      default:   rd_val = '0;
    endcase
  end

  // ready is a one-cycle pulse, so a new request cannot be accepted on the edge after one completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= accept;
      if (accept) rdata <= rd_val;
    end
  end

  assign mtip = (mtime >= mtimecmp);
  assign msip = msip_r;

endmodule

// File: tb/tb_my_clint.sv
// tb_my_clint: randomized scoreboard bench for my_clint (default build, mtime ticks every clock).
// mtime is modelled as base value plus elapsed clock edges; bus reads are checked in a monitor.
module tb_my_clint;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        mtip;
  logic        msip;

  always #5 clk = ~clk;

  my_clint dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .mtip(mtip), .msip(msip)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] edge_cnt;
  logic [63:0] m_base_val;
  logic [63:0] m_base_edge;
  logic [63:0] m_cmp;
  logic        m_msip;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always @(posedge clk or posedge rst)
    if (rst) edge_cnt <= '0;
    else     edge_cnt <= edge_cnt + 64'd1;

  function automatic logic [63:0] m_time(input logic [63:0] k);
    return m_base_val + (k - m_base_edge);
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request; the expected read data and the model update follow the accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [63:0] k, v, vn;
    logic [15:0] off;
    logic [31:0] exp;
    bit          got;
    @(negedge clk);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    k   = edge_cnt + 64'd1;
    v   = m_time(edge_cnt);
    vn  = v + 64'd1;
    off = a[15:0] & 16'hFFFC;
    case (off)
      16'h0000: exp = {31'd0, m_msip};
      16'h4000: exp = m_cmp[31:0];
      16'h4004: exp = m_cmp[63:32];
      16'hBFF8: exp = v[31:0];
      16'hBFFC: exp = v[63:32];
      default:  exp = 32'd0;
    endcase
    exp_q.push_back(exp);
    tag_q.push_back($sformatf("rdata@%h", a[15:0]));
    @(posedge clk); #1;
    if (s != 4'd0) begin
      case (off)
        16'h0000: if (s[0]) m_msip = d[0];
        16'h4000: m_cmp[31:0]  = lane_merge(m_cmp[31:0], d, s);
        16'h4004: m_cmp[63:32] = lane_merge(m_cmp[63:32], d, s);
        16'hBFF8: begin m_base_val = {vn[63:32], lane_merge(v[31:0], d, s)}; m_base_edge = k; end
        16'hBFFC: begin m_base_val = {lane_merge(v[63:32], d, s), vn[31:0]}; m_base_edge = k; end
        default: ;
      endcase
    end
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1'b1;
    end
    valid = 1'b0;
    if (!got) begin
      n_vec++; n_err++;
      $display("[TB] FAIL ready_timeout: got no ready expected ready for %h", a);
      if (exp_q.size() != 0) begin void'(exp_q.pop_front()); void'(tag_q.pop_front()); end
    end
  endtask

  task automatic doReset();
    rst = 1'b1; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
    #1;
    checkOutput("reset_ready", {63'd0, ready}, 64'd0);
    checkOutput("reset_rdata", {32'd0, rdata}, 64'd0);
    checkOutput("reset_mtip",  {63'd0, mtip},  64'd0);
    checkOutput("reset_msip",  {63'd0, msip},  64'd0);
    @(negedge clk); @(negedge clk);
    m_base_val = '0; m_base_edge = '0; m_cmp = '1; m_msip = 1'b0;
    exp_q.delete(); tag_q.delete();
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every ready and tracks the interrupt lines each cycle.
  logic [31:0] mon_exp;
  string       mon_tag;
  always @(negedge clk) begin
    if (!rst) begin
      if (ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("[TB] FAIL unexpected_ready: got ready=1 expected no pending request");
        end else begin
          mon_exp = exp_q.pop_front();
          mon_tag = tag_q.pop_front();
          checkOutput(mon_tag, {32'd0, rdata}, {32'd0, mon_exp});
        end
      end
      checkOutput("mtip", {63'd0, mtip}, {63'd0, (m_time(edge_cnt) >= m_cmp)});
      checkOutput("msip", {63'd0, msip}, {63'd0, m_msip});
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  logic [63:0] target;
  logic [15:0] bases[6];

  initial begin
    bases = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h1234};
    doReset();

    applyStimulus(32'h0000BFF8, 32'd0, 4'b0000);
    applyStimulus(32'h0000BFFC, 32'd0, 4'b0000);
    applyStimulus(32'h00004000, 32'd0, 4'b0000);
    applyStimulus(32'h00004004, 32'd0, 4'b0000);
    applyStimulus(32'h00000000, 32'd0, 4'b0000);

    applyStimulus(32'h00000000, 32'd1, 4'b0001);
    applyStimulus(32'h00000000, 32'd0, 4'b0000);
    applyStimulus(32'h00000000, 32'd0, 4'b0001);
    applyStimulus(32'h00000000, 32'd0, 4'b0000);

    target = m_time(edge_cnt) + 64'd50;
    applyStimulus(32'h00004004, target[63:32], 4'b1111);
    applyStimulus(32'h00004000, target[31:0],  4'b1111);
    repeat (70) @(negedge clk);
    applyStimulus(32'h00004004, 32'hFFFFFFFF, 4'b1111);

    applyStimulus(32'h0000BFFC, 32'd0, 4'b1111);
    applyStimulus(32'h0000BFF8, 32'hFFFFFFFF, 4'b1111);
    applyStimulus(32'h0000BFFC, 32'd0, 4'b0000);
    applyStimulus(32'h0000BFF8, 32'd0, 4'b0000);

    applyStimulus(32'h00004000, 32'h11223344, 4'b1111);
    applyStimulus(32'h00004000, 32'hAABBCCDD, 4'b0010);
    applyStimulus(32'h00004000, 32'd0, 4'b0000);
    applyStimulus(32'h00001234, 32'hDEADBEEF, 4'b1111);
    applyStimulus(32'h00001234, 32'd0, 4'b0000);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [3:0]  s;
      a = {16'($urandom), bases[$urandom_range(0, 5)]} | 32'($urandom_range(0, 3));
      s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      applyStimulus(a, $urandom, s);
    end

    applyStimulus(32'h00004004, 32'd0, 4'b1111);
    applyStimulus(32'h00004000, 32'd0, 4'b1111);
    @(negedge clk);
    valid = 1'b1; address = 32'h0; wdata = 32'd1; wstrb = 4'b0001;
    @(posedge clk); #1;
    checkOutput("abort_accepted", {63'd0, ready}, 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_ready", {63'd0, ready}, 64'd0);
    checkOutput("abort_msip",  {63'd0, msip},  64'd0);
    checkOutput("abort_mtip",  {63'd0, mtip},  64'd0);
    doReset();
    applyStimulus(32'h00004000, 32'd0, 4'b0000);
    applyStimulus(32'h00004004, 32'd0, 4'b0000);
    applyStimulus(32'h00000000, 32'd0, 4'b0000);
    applyStimulus(32'h0000BFFC, 32'd0, 4'b0000);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
